// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter in front of one single-port synchronous memory.
// Fair alternation on ties, bounded bus locking and registered read-valid per master.
module mem_bus_arbiter #(
    parameter int ADDR_W   = 24,
    parameter int DATA_W   = 12,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_lock,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m0_we,
    input  logic              m1_we,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

    state_t     state_q, state_d;
    logic       last_owner_q, last_owner_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic       m0_rvalid_q, m1_rvalid_q;

    logic xfer0, xfer1;
    logic own_req, own_lock, oth_req;
    logic lock_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            lock_cnt_q   <= '0;
            m0_rvalid_q  <= 1'b0;
            m1_rvalid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            m0_rvalid_q  <= xfer0 & ~m0_we;
            m1_rvalid_q  <= xfer1 & ~m1_we;
        end
    end

    always_comb begin
        xfer0    = (state_q == OWN0) & m0_req;
        xfer1    = (state_q == OWN1) & m1_req;
        lock_hit = (lock_cnt_q >= LOCK_LIMIT);
        own_req  = 1'b0;
        own_lock = 1'b0;
        oth_req  = 1'b0;
        case (state_q)
            OWN0: begin
                own_req  = m0_req;
                own_lock = m0_lock;
                oth_req  = m1_req;
            end
            OWN1: begin
                own_req  = m1_req;
                own_lock = m1_lock;
                oth_req  = m0_req;
            end
            default: ;
        endcase

        // Tie-break must see this cycle's transfer so continuous ties alternate.
        last_owner_d = last_owner_q;
        if (xfer0) begin
            last_owner_d = 1'b0;
        end else if (xfer1) begin
            last_owner_d = 1'b1;
        end

        state_d    = IDLE;
        lock_cnt_d = '0;
        if (state_q != IDLE && own_req && own_lock && (!lock_hit || !oth_req)) begin
            state_d    = state_q;
            lock_cnt_d = oth_req ? lock_cnt_q + 8'd1 : lock_cnt_q;
        end else begin
            // An expired lock falls through here: the owner just transferred, so a tie goes to the other.
            case ({m1_req, m0_req})
                2'b11:   state_d = last_owner_d ? OWN0 : OWN1;
                2'b01:   state_d = OWN0;
                2'b10:   state_d = OWN1;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        case (state_q)
            OWN0: begin
                mem_addr  = m0_addr;
                mem_wdata = m0_wdata;
                mem_we    = m0_req & m0_we;
            end
            OWN1: begin
                mem_addr  = m1_addr;
                mem_wdata = m1_wdata;
                mem_we    = m1_req & m1_we;
            end
            default: ;
        endcase
    end

    assign m0_gnt    = (state_q == OWN0);
    assign m1_gnt    = (state_q == OWN1);
    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios then random traffic, every cycle
// compared against a transaction-level model of owner, tie-break, lock budget and memory.
module tb_mem_bus_arbiter;

    localparam int AW = 24;
    localparam int DW = 12;
    localparam int LM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m1_req, m0_lock, m1_lock, m0_we, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m1_req(m1_req), .m0_lock(m0_lock), .m1_lock(m1_lock),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_we(m0_we), .m1_we(m1_we), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory device attached to the arbiter (low 8 address bits decoded)
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr[7:0]];
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end

    function automatic logic [DW-1:0] init_val(input int k);
        return (k == 8) ? 12'o1234 : 12'(k * 53 + 7);
    endfunction

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner -1 = idle
    int            own, last, lcnt;
    bit            erv [2];
    logic [DW-1:0] erd;
    logic [DW-1:0] emem [256];

    task automatic step_cycle();
        bit            req [2], lck [2], we [2];
        logic [AW-1:0] ad [2];
        logic [DW-1:0] wd [2];
        int            other, nxt;
        bit            xfer;
        #1;
        req = '{m0_req, m1_req};
        lck = '{m0_lock, m1_lock};
        we  = '{m0_we, m1_we};
        ad  = '{m0_addr, m1_addr};
        wd  = '{m0_wdata, m1_wdata};
        if (rst) begin
            own = -1; last = 1; lcnt = 0; erv = '{0, 0};
        end
        chk("gnt0", m0_gnt, own == 0);
        chk("gnt1", m1_gnt, own == 1);
        chk("gnt_excl", m0_gnt & m1_gnt, 0);
        chk("rv_excl", m0_rvalid & m1_rvalid, 0);
        chk("rvalid0", m0_rvalid, erv[0]);
        chk("rvalid1", m1_rvalid, erv[1]);
        if (erv[0] || erv[1]) chk("rdata", rdata, erd);
        chk("mem_we", mem_we, (own >= 0) ? (req[own] & we[own]) : 1'b0);
        chk("mem_addr", mem_addr, (own >= 0) ? ad[own] : '0);
        chk("mem_wdata", mem_wdata, (own >= 0) ? wd[own] : '0);
        $display("t=%0t rst=%0d req=%0d%0d lock=%0d%0d owner=%0d gnt=%0d%0d we=%0d addr=%0h",
                 $time, rst, req[0], req[1], lck[0], lck[1], own, m0_gnt, m1_gnt, mem_we, mem_addr);
        if (!rst) begin
            xfer = (own >= 0) && req[own];
            erv = '{0, 0};
            if (xfer) begin
                last = own;
                if (!we[own]) begin
                    erv[own] = 1;
                    erd = emem[ad[own][7:0]];
                end else begin
                    emem[ad[own][7:0]] = wd[own];
                end
            end
            other = 1 - own;
            if (xfer && lck[own] && (lcnt < LM || !req[other])) begin
                if (req[other]) lcnt = (lcnt + 1 > LM) ? LM : lcnt + 1;
            end else begin
                if (req[0] && req[1]) nxt = 1 - last;
                else if (req[0])      nxt = 0;
                else if (req[1])      nxt = 1;
                else                  nxt = -1;
                own  = nxt;
                lcnt = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_req = 0; m1_req = 0; m0_lock = 0; m1_lock = 0; m0_we = 0; m1_we = 0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            mem[k]  = init_val(k);
            emem[k] = init_val(k);
        end
        own = -1; last = 1; lcnt = 0; erv = '{0, 0}; erd = '0;
        idle_inputs();
        rst = 1;
        @(negedge clk);
        step_cycle();
        rst = 0;
        step_cycle();

        // m0 read from 0o10
        m0_req = 1; m0_addr = 24'o10;
        step_cycle();
        chk("r1_gnt", m0_gnt, 1);
        chk("r1_addr", mem_addr, 24'o10);
        step_cycle();
        chk("r1_rvalid", m0_rvalid, 1);
        chk("r1_rdata", rdata, 12'o1234);
        m0_req = 0;
        step_cycle();

        // Both request from reset: m0,m1,m0,m1
        rst = 1;
        step_cycle();
        rst = 0;
        m0_req = 1; m1_req = 1; m0_addr = 24'd3; m1_addr = 24'd4;
        step_cycle();
        for (int k = 0; k < 4; k++) begin
            chk("tie_m0", m0_gnt, (k % 2) == 0);
            chk("tie_m1", m1_gnt, (k % 2) == 1);
            step_cycle();
        end

        // m1 locked write, m0 idle, 20 cycles
        m0_req = 0; m1_lock = 1; m1_we = 1; m1_addr = 24'o5; m1_wdata = 12'o7777;
        step_cycle();
        for (int k = 0; k < 20; k++) begin
            chk("lk_m1", m1_gnt, 1);
            chk("lk_m0", m0_gnt, 0);
            chk("lk_we", mem_we, 1);
            step_cycle();
        end

        // m0 locked, then m1 requests: lock budget expires after LM cycles
        m1_req = 0; m1_lock = 0; m1_we = 0;
        m0_req = 1; m0_lock = 1; m0_addr = 24'o5;
        step_cycle();
        step_cycle();
        step_cycle();
        m1_req = 1;
        for (int k = 0; k <= LM; k++) begin
            step_cycle();
            chk("lmax_m0", m0_gnt, k < LM);
            chk("lmax_m1", m1_gnt, k == LM);
        end

        // Reset pulsed during an m0 write
        m1_req = 0; m0_lock = 0; m0_we = 1; m0_wdata = 12'o4321; m0_addr = 24'd9;
        step_cycle();
        step_cycle();
        chk("rw_gnt", m0_gnt, 1);
        chk("rw_we", mem_we, 1);
        rst = 1;
        #1;
        chk("rst_we", mem_we, 0);
        chk("rst_gnt", m0_gnt | m1_gnt, 0);
        chk("rst_rv", m0_rvalid | m1_rvalid, 0);
        step_cycle();
        rst = 0;
        m0_we = 0; m1_req = 1;
        step_cycle();
        chk("rst_tie", m0_gnt, 1);

        // m0 drops req while granted, m1 waiting
        m0_req = 0;
        step_cycle();
        chk("drop_m1", m1_gnt, 1);
        chk("drop_rv0", m0_rvalid, 0);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            rst      = ($urandom_range(99) == 0);
            m0_req   = ($urandom_range(3) != 0);
            m1_req   = ($urandom_range(3) != 0);
            m0_lock  = ($urandom_range(2) == 0);
            m1_lock  = ($urandom_range(2) == 0);
            m0_we    = $urandom_range(1);
            m1_we    = $urandom_range(1);
            m0_addr  = AW'($urandom);
            m1_addr  = AW'($urandom);
            m0_wdata = DW'($urandom);
            m1_wdata = DW'($urandom);
            step_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, memory address width.
REQ-002 SHALL have parameter DATA_W, default 12, memory word width.
REQ-003 SHALL have parameter LOCK_MAX, default 16, maximum consecutive locked-grant cycles while the other master waits (range 1..255).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports m0_req, m1_req  input  1  master i requests one transfer.
REQ-007 SHALL have ports m0_lock, m1_lock  input  1  master i asks to keep ownership after the current transfer.
REQ-008 SHALL have ports m0_addr, m1_addr  input  ADDR_W  transfer address.
REQ-009 SHALL have ports m0_wdata, m1_wdata  input  DATA_W  write data.
REQ-010 SHALL have ports m0_we, m1_we  input  1  1 = write, 0 = read.
REQ-011 SHALL have ports m0_gnt, m1_gnt  output  1  master i owns the bus this cycle.
REQ-012 SHALL have ports m0_rvalid, m1_rvalid  output  1  read data for master i valid this cycle.
REQ-013 SHALL have port rdata  output  DATA_W  shared read data, equal to mem_rdata.
REQ-014 SHALL have ports mem_addr  output  ADDR_W, mem_wdata  output  DATA_W, mem_we  output  1  to single-port memory.
REQ-015 SHALL have port mem_rdata  input  DATA_W  synchronous memory read data, one cycle after address.

Function
REQ-016 SHALL implement FSM states IDLE, OWN0, OWN1; mi_gnt = 1 exactly in OWNi.
REQ-017 SHALL count a transfer for master i in every cycle with mi_gnt & mi_req; no transfer otherwise.
REQ-018 SHALL drive mem_addr/mem_wdata combinationally from the owner; mem_we = mi_gnt & mi_req & mi_we; in IDLE mem_addr = 0, mem_wdata = 0, mem_we = 0.
REQ-019 SHALL register mi_rvalid <= mi_gnt & mi_req & ~mi_we (read data one cycle after the transfer cycle).
REQ-020 SHALL keep last_owner, updated to i on each transfer by master i.
REQ-021 SHALL, at each edge in OWNi with mi_req & mi_lock & (lock_cnt < LOCK_MAX or other master not requesting), stay in OWNi.
REQ-022 SHALL otherwise arbitrate on current requests: both -> master != last_owner; one -> that master; none -> IDLE.
REQ-023 SHALL give grant latency of exactly one cycle: req sampled at edge N, gnt high in cycle N+1 when won.
REQ-024 SHALL clear lock_cnt on entering any state or changing owner; increment (saturating at LOCK_MAX) on each locked cycle where the other master requests.
REQ-025 SHALL force release when lock_cnt reaches LOCK_MAX and the other master requests: next state OWN(other), regardless of lock.
REQ-026 SHALL treat req dropped while granted as no transfer; ownership then follows REQ-022.
REQ-027 SHALL give a single requester a transfer every cycle (back-to-back) with no idle bubble.
REQ-028 SHALL alternate owners every cycle when both request continuously without lock.
REQ-029 SHALL never assert m0_gnt and m1_gnt together, nor m0_rvalid and m1_rvalid together.

Reset
REQ-030 SHALL on rst asynchronously force: state IDLE, m0_gnt = m1_gnt = 0, m0_rvalid = m1_rvalid = 0, mem_we = 0, last_owner = 1 (m0 wins first tie), lock_cnt = 0.
REQ-031 SHALL, on rst asserted mid-transfer, drop mem_we in the same cycle and discard pending rvalid; first grant after release one cycle after a sampled req.

Verification
REQ-032 SHALL verify: reset release, m0 read addr 0o000010 (mem=0o1234) -> m0_gnt next cycle, mem_addr=0o000010, m0_rvalid + rdata=0o1234 one cycle later.
REQ-033 SHALL verify: both req from reset, no lock -> grant order m0,m1,m0,m1; never both gnt.
REQ-034 SHALL verify: m1 write 0o7777 to 0o000005 with lock, m0 idle, 20 cycles -> m1_gnt held 20 cycles, mem_we=1, m0_gnt=0.
REQ-035 SHALL verify: m0 locked, m1 requests, LOCK_MAX=4 -> m0 keeps 4 cycles after m1 req, then m1_gnt, m0_gnt=0.
REQ-036 SHALL verify: rst pulsed during m0 write -> mem_we=0 immediately, all gnt/rvalid 0, tie after reset goes to m0.
REQ-037 SHALL verify: m0 drops req while granted, m1 requesting -> no m0 transfer, m1_gnt next cycle.
